// File: rtl/vid_palette_banked.sv
// Multi-bank palette RAM: bus write port, whole-bank fill engine, vsync-timed
// display-bank swap and a fixed-latency scanout read port.
module vid_palette_banked #(
  parameter  int ADDR_W  = 8,
  parameter  int DATA_W  = 24,
  parameter  int N_BANKS = 2,
  parameter  int RD_LAT  = 1,
  localparam int BANK_W  = (N_BANKS > 1) ? $clog2(N_BANKS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [BANK_W-1:0] w_bank,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic [DATA_W-1:0] w_data,
  input  logic              w_valid,
  output logic              w_ready,
  input  logic              fill_start,
  input  logic [BANK_W-1:0] fill_bank,
  input  logic [DATA_W-1:0] fill_data,
  output logic              fill_busy,
  output logic              fill_done,
  input  logic              sel_valid,
  input  logic [BANK_W-1:0] sel_bank,
  input  logic              vsync,
  output logic              swap_ack,
  output logic [BANK_W-1:0] disp_bank,
  input  logic [ADDR_W-1:0] r_addr,
  output logic [DATA_W-1:0] r_data
);

  localparam int DEPTH     = 1 << ADDR_W;
  localparam int MEM_AW    = BANK_W + ADDR_W;
  localparam int MEM_WORDS = N_BANKS * DEPTH;
  // A single-bank build forces every bank index to zero.
  localparam logic [BANK_W-1:0] BANK_MASK = (N_BANKS > 1) ? {BANK_W{1'b1}} : {BANK_W{1'b0}};
  localparam logic [ADDR_W-1:0] CNT_LAST  = {ADDR_W{1'b1}};

  typedef enum logic {
    FILL_IDLE,
    FILL_RUN
  } fill_state_e;

  // Fill engine state
  fill_state_e       fill_state_q, fill_state_d;
  logic [ADDR_W-1:0] fill_cnt_q, fill_cnt_d;
  logic [BANK_W-1:0] fill_bank_q, fill_bank_d;
  logic [DATA_W-1:0] fill_data_q, fill_data_d;
  logic              fill_done_q, fill_done_d;

  // Swap state
  logic              pend_q, pend_d;
  logic [BANK_W-1:0] pend_bank_q, pend_bank_d;
  logic [BANK_W-1:0] disp_bank_q, disp_bank_d;
  logic              swap_ack_q, swap_ack_d;
  logic              swap_blocked;

  // RAM ports
  logic              ram_we;
  logic [MEM_AW-1:0] ram_waddr;
  logic [DATA_W-1:0] ram_wdata;
  logic [MEM_AW-1:0] rd_idx;
  logic [DATA_W-1:0] rd_data_q;
  logic [DATA_W-1:0] mem [MEM_WORDS];

  assign fill_busy = (fill_state_q == FILL_RUN);
  assign w_ready   = ~fill_busy;
  assign fill_done = fill_done_q;
  assign swap_ack  = swap_ack_q;
  assign disp_bank = disp_bank_q;

  always_comb begin
    fill_state_d = fill_state_q;
    fill_cnt_d   = fill_cnt_q;
    fill_bank_d  = fill_bank_q;
    fill_data_d  = fill_data_q;
    fill_done_d  = 1'b0;
    case (fill_state_q)
      FILL_IDLE: begin
        if (fill_start) begin
          fill_state_d = FILL_RUN;
          fill_cnt_d   = '0;
          fill_bank_d  = fill_bank & BANK_MASK;
          fill_data_d  = fill_data;
        end
      end
      FILL_RUN: begin
        fill_cnt_d = fill_cnt_q + 1'b1;
        if (fill_cnt_q == CNT_LAST) begin
          fill_state_d = FILL_IDLE;
          fill_done_d  = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_state_q <= FILL_IDLE;
      fill_cnt_q   <= '0;
      fill_bank_q  <= '0;
      fill_data_q  <= '0;
      fill_done_q  <= 1'b0;
    end else begin
      fill_state_q <= fill_state_d;
      fill_cnt_q   <= fill_cnt_d;
      fill_bank_q  <= fill_bank_d;
      fill_data_q  <= fill_data_d;
      fill_done_q  <= fill_done_d;
    end
  end

  // A swap into the bank being filled waits for a later vsync.
  assign swap_blocked = fill_busy && (pend_bank_q == fill_bank_q);

  always_comb begin
    pend_d      = pend_q;
    pend_bank_d = pend_bank_q;
    disp_bank_d = disp_bank_q;
    swap_ack_d  = 1'b0;
    if (vsync && pend_q && !swap_blocked) begin
      disp_bank_d = pend_bank_q;
      pend_d      = 1'b0;
      swap_ack_d  = 1'b1;
    end
    // A request arriving with vsync is kept for the next frame boundary.
    if (sel_valid) begin
      pend_d      = 1'b1;
      pend_bank_d = sel_bank & BANK_MASK;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q      <= 1'b0;
      pend_bank_q <= '0;
      disp_bank_q <= '0;
      swap_ack_q  <= 1'b0;
    end else begin
      pend_q      <= pend_d;
      pend_bank_q <= pend_bank_d;
      disp_bank_q <= disp_bank_d;
      swap_ack_q  <= swap_ack_d;
    end
  end

  // The fill engine owns the write port while busy; w_ready is low then.
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = {fill_bank_q, fill_cnt_q};
    ram_wdata = fill_data_q;
    if (fill_busy) begin
      ram_we = 1'b1;
    end else if (w_valid) begin
      ram_we    = 1'b1;
      ram_waddr = {w_bank & BANK_MASK, w_addr};
      ram_wdata = w_data;
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) begin
      mem[ram_waddr] <= ram_wdata;
    end
  end

  assign rd_idx = {disp_bank_q, r_addr};

  // Registered read: a same-cycle write to this word is seen on the next read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= mem[rd_idx];
    end
  end

  generate
    if (RD_LAT == 2) begin : g_lat2
      logic [DATA_W-1:0] rd_pipe_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rd_pipe_q <= '0;
        end else begin
          rd_pipe_q <= rd_data_q;
        end
      end
      assign r_data = rd_pipe_q;
    end else begin : g_lat1
      assign r_data = rd_data_q;
    end
  endgenerate

endmodule

// File: tb/tb_vid_palette_banked.sv
// Scoreboard bench for vid_palette_banked: two instances share the stimulus,
// one with 1-cycle and one with 2-cycle read latency.
module tb_vid_palette_banked;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        w_bank = 1'b0;
  logic [7:0]  w_addr = '0;
  logic [23:0] w_data = '0;
  logic        w_valid = 1'b0;
  logic        fill_start = 1'b0;
  logic        fill_bank = 1'b0;
  logic [23:0] fill_data = '0;
  logic        sel_valid = 1'b0;
  logic        sel_bank = 1'b0;
  logic        vsync = 1'b0;
  logic [7:0]  r_addr = '0;

  logic        w_ready1, fill_busy1, fill_done1, swap_ack1, disp_bank1;
  logic [23:0] r_data1;
  logic        w_ready2, fill_busy2, fill_done2, swap_ack2, disp_bank2;
  logic [23:0] r_data2;

  always #5 clk = ~clk;

  vid_palette_banked #(.ADDR_W(8), .DATA_W(24), .N_BANKS(2), .RD_LAT(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .w_bank(w_bank), .w_addr(w_addr), .w_data(w_data), .w_valid(w_valid), .w_ready(w_ready1),
    .fill_start(fill_start), .fill_bank(fill_bank), .fill_data(fill_data),
    .fill_busy(fill_busy1), .fill_done(fill_done1),
    .sel_valid(sel_valid), .sel_bank(sel_bank), .vsync(vsync),
    .swap_ack(swap_ack1), .disp_bank(disp_bank1),
    .r_addr(r_addr), .r_data(r_data1)
  );

  vid_palette_banked #(.ADDR_W(8), .DATA_W(24), .N_BANKS(2), .RD_LAT(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n),
    .w_bank(w_bank), .w_addr(w_addr), .w_data(w_data), .w_valid(w_valid), .w_ready(w_ready2),
    .fill_start(fill_start), .fill_bank(fill_bank), .fill_data(fill_data),
    .fill_busy(fill_busy2), .fill_done(fill_done2),
    .sel_valid(sel_valid), .sel_bank(sel_bank), .vsync(vsync),
    .swap_ack(swap_ack2), .disp_bank(disp_bank2),
    .r_addr(r_addr), .r_data(r_data2)
  );

  typedef struct {
    logic [23:0] exp;
    int          due;
    int          addr;
  } sb_t;

  sb_t         sb1[$];
  sb_t         sb2[$];
  logic [23:0] model_mem [2][256];
  int          model_disp = 0;
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Present a scanout address and queue what each latency variant must return.
  task automatic push_read(input int addr);
    sb_t e;
    r_addr = addr[7:0];
    e.exp  = model_mem[model_disp][addr];
    e.addr = addr;
    e.due  = cyc + 1;
    sb1.push_back(e);
    e.due  = cyc + 2;
    sb2.push_back(e);
  endtask

  task automatic do_write(input logic bank, input int addr, input logic [23:0] data);
    w_valid = 1'b1;
    w_bank  = bank;
    w_addr  = addr[7:0];
    w_data  = data;
    tick();
    w_valid = 1'b0;
    model_mem[bank][addr] = data;
  endtask

  task automatic test_reset;
    repeat (3) tick();
    total++;
    if (w_ready1 !== 1'b1 || fill_busy1 !== 1'b0 || fill_done1 !== 1'b0 ||
        swap_ack1 !== 1'b0 || disp_bank1 !== 1'b0 || r_data1 !== 24'h0) begin
      bad++;
      $display("FAIL reset_lat1 got rdy=%b busy=%b done=%b ack=%b disp=%b rd=%h want 1 0 0 0 0 000000",
               w_ready1, fill_busy1, fill_done1, swap_ack1, disp_bank1, r_data1);
    end
    total++;
    if (w_ready2 !== 1'b1 || fill_busy2 !== 1'b0 || fill_done2 !== 1'b0 ||
        swap_ack2 !== 1'b0 || disp_bank2 !== 1'b0 || r_data2 !== 24'h0) begin
      bad++;
      $display("FAIL reset_lat2 got rdy=%b busy=%b done=%b ack=%b disp=%b rd=%h want 1 0 0 0 0 000000",
               w_ready2, fill_busy2, fill_done2, swap_ack2, disp_bank2, r_data2);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_read_latency;
    int  rd_list[8];
    sb_t ent;
    do_write(1'b0, 'h10, 24'h123456);
    repeat (2) tick();
    for (int i = 0; i < 4; i++) do_write(1'b0, i, 24'h0A0000 + 24'(i));
    do_write(1'b0, 'h20, 24'h0000A1);
    rd_list = '{'h10, 0, 1, 2, 3, 'h20, 'h20, 'h10};
    for (int i = 0; i < 10; i++) begin
      if (i < 8) push_read(rd_list[i]);
      if (i == 5) begin
        // Write and read the same word together: the read sees the old colour.
        w_valid = 1'b1; w_bank = 1'b0; w_addr = 8'h20; w_data = 24'h0000B2;
      end else begin
        w_valid = 1'b0;
      end
      tick();
      if (i == 5) model_mem[0]['h20] = 24'h0000B2;
      while (sb1.size() > 0 && sb1[0].due <= cyc) begin
        ent = sb1.pop_front();
        total++;
        if (r_data1 !== ent.exp) begin
          bad++;
          $display("FAIL rd_lat1 addr=%02h got=%06h want=%06h", ent.addr, r_data1, ent.exp);
        end
      end
      while (sb2.size() > 0 && sb2[0].due <= cyc) begin
        ent = sb2.pop_front();
        total++;
        if (r_data2 !== ent.exp) begin
          bad++;
          $display("FAIL rd_lat2 addr=%02h got=%06h want=%06h", ent.addr, r_data2, ent.exp);
        end
      end
    end
    w_valid = 1'b0;
  endtask

  task automatic test_fill;
    int busy_cnt;
    int rdy_bad;
    fill_start = 1'b1; fill_bank = 1'b1; fill_data = 24'hFF00FF;
    w_valid = 1'b1; w_bank = 1'b0; w_addr = 8'h30; w_data = 24'hABCDEF;
    tick();
    model_mem[0]['h30] = 24'hABCDEF;
    fill_start = 1'b0;
    w_addr = 8'h31; w_data = 24'h0A0B0C;
    busy_cnt = 0;
    rdy_bad = 0;
    while (fill_busy1 === 1'b1 && busy_cnt < 1000) begin
      if (w_ready1 !== 1'b0 || fill_done1 !== 1'b0) rdy_bad++;
      busy_cnt++;
      tick();
    end
    total++;
    if (busy_cnt !== 256) begin
      bad++;
      $display("FAIL fill_busy_len got=%0d want=256", busy_cnt);
    end
    total++;
    if (rdy_bad !== 0) begin
      bad++;
      $display("FAIL fill_ready_low got=%0d bad cycles want=0", rdy_bad);
    end
    total++;
    if (fill_done1 !== 1'b1 || w_ready1 !== 1'b1) begin
      bad++;
      $display("FAIL fill_done_pulse got done=%b rdy=%b want 1 1", fill_done1, w_ready1);
    end
    tick();
    w_valid = 1'b0;
    model_mem[0]['h31] = 24'h0A0B0C;
    for (int i = 0; i < 256; i++) model_mem[1][i] = 24'hFF00FF;
    total++;
    if (fill_done1 !== 1'b0) begin
      bad++;
      $display("FAIL fill_done_single got=%b want=0", fill_done1);
    end
  endtask

  task automatic test_swap;
    int  rd_list[9];
    sb_t ent;
    rd_list = '{0, 'h30, 'h31, 'h20, 0, 1, 'h10, 0, 0};
    sel_valid = 1'b1; sel_bank = 1'b1;
    for (int i = 0; i < 14; i++) begin
      if (i == 10) vsync = 1'b1;
      if (i < 9) push_read(rd_list[i]);
      else if (i < 12) push_read(i == 11 ? 5 : 0);
      tick();
      sel_valid = 1'b0;
      if (i == 9) begin
        total++;
        if (disp_bank1 !== 1'b0 || swap_ack1 !== 1'b0) begin
          bad++;
          $display("FAIL swap_early got disp=%b ack=%b want 0 0", disp_bank1, swap_ack1);
        end
      end
      if (i == 10) begin
        vsync = 1'b0;
        model_disp = 1;
        total++;
        if (disp_bank1 !== 1'b1 || swap_ack1 !== 1'b1 || disp_bank2 !== 1'b1) begin
          bad++;
          $display("FAIL swap_apply got disp=%b ack=%b disp2=%b want 1 1 1", disp_bank1, swap_ack1, disp_bank2);
        end
      end
      if (i == 11) begin
        total++;
        if (swap_ack1 !== 1'b0) begin
          bad++;
          $display("FAIL swap_ack_single got=%b want=0", swap_ack1);
        end
      end
      while (sb1.size() > 0 && sb1[0].due <= cyc) begin
        ent = sb1.pop_front();
        total++;
        if (r_data1 !== ent.exp) begin
          bad++;
          $display("FAIL swap_rd_lat1 addr=%02h got=%06h want=%06h", ent.addr, r_data1, ent.exp);
        end
      end
      while (sb2.size() > 0 && sb2[0].due <= cyc) begin
        ent = sb2.pop_front();
        total++;
        if (r_data2 !== ent.exp) begin
          bad++;
          $display("FAIL swap_rd_lat2 addr=%02h got=%06h want=%06h", ent.addr, r_data2, ent.exp);
        end
      end
    end
  endtask

  task automatic test_swap_blocked;
    int guard;
    fill_start = 1'b1; fill_bank = 1'b0; fill_data = 24'h00AA55;
    tick();
    fill_start = 1'b0;
    sel_valid = 1'b1; sel_bank = 1'b0;
    tick();
    sel_valid = 1'b0;
    repeat (5) tick();
    vsync = 1'b1;
    tick();
    vsync = 1'b0;
    total++;
    if (disp_bank1 !== 1'b1 || swap_ack1 !== 1'b0) begin
      bad++;
      $display("FAIL swap_blocked got disp=%b ack=%b want 1 0", disp_bank1, swap_ack1);
    end
    guard = 0;
    while (fill_busy1 === 1'b1 && guard < 1000) begin
      guard++;
      tick();
    end
    total++;
    if (fill_done1 !== 1'b1 || disp_bank1 !== 1'b1) begin
      bad++;
      $display("FAIL blocked_fill_end got done=%b disp=%b want 1 1", fill_done1, disp_bank1);
    end
    vsync = 1'b1;
    tick();
    vsync = 1'b0;
    model_disp = 0;
    for (int i = 0; i < 256; i++) model_mem[0][i] = 24'h00AA55;
    total++;
    if (disp_bank1 !== 1'b0 || swap_ack1 !== 1'b1) begin
      bad++;
      $display("FAIL swap_retry got disp=%b ack=%b want 0 1", disp_bank1, swap_ack1);
    end
    vsync = 1'b1;
    tick();
    vsync = 1'b0;
    total++;
    if (disp_bank1 !== 1'b0 || swap_ack1 !== 1'b0) begin
      bad++;
      $display("FAIL vsync_no_pend got disp=%b ack=%b want 0 0", disp_bank1, swap_ack1);
    end
  endtask

  task automatic test_sel_vsync_same;
    sel_valid = 1'b1; sel_bank = 1'b1; vsync = 1'b1;
    tick();
    sel_valid = 1'b0; vsync = 1'b0;
    total++;
    if (disp_bank1 !== 1'b0 || swap_ack1 !== 1'b0) begin
      bad++;
      $display("FAIL same_cycle_sel got disp=%b ack=%b want 0 0", disp_bank1, swap_ack1);
    end
    repeat (3) tick();
    vsync = 1'b1;
    tick();
    vsync = 1'b0;
    model_disp = 1;
    total++;
    if (disp_bank1 !== 1'b1 || swap_ack1 !== 1'b1) begin
      bad++;
      $display("FAIL same_cycle_next got disp=%b ack=%b want 1 1", disp_bank1, swap_ack1);
    end
    sel_valid = 1'b1; sel_bank = 1'b1;
    tick();
    sel_valid = 1'b0; vsync = 1'b1;
    tick();
    vsync = 1'b0;
    total++;
    if (disp_bank1 !== 1'b1 || swap_ack1 !== 1'b1) begin
      bad++;
      $display("FAIL reselect_same got disp=%b ack=%b want 1 1", disp_bank1, swap_ack1);
    end
    sel_valid = 1'b1; sel_bank = 1'b0;
    tick();
    sel_bank = 1'b1;
    tick();
    sel_valid = 1'b0; vsync = 1'b1;
    tick();
    vsync = 1'b0;
    total++;
    if (disp_bank1 !== 1'b1 || swap_ack1 !== 1'b1) begin
      bad++;
      $display("FAIL sel_overwrite got disp=%b ack=%b want 1 1", disp_bank1, swap_ack1);
    end
  endtask

  task automatic test_reset_mid_fill;
    int busy_cnt;
    r_addr = 8'hF0;
    fill_start = 1'b1; fill_bank = 1'b1; fill_data = 24'h112233;
    tick();
    fill_start = 1'b0;
    sel_valid = 1'b1; sel_bank = 1'b0;
    tick();
    sel_valid = 1'b0;
    repeat (99) tick();
    total++;
    if (r_data1 !== 24'hFF00FF || fill_busy1 !== 1'b1) begin
      bad++;
      $display("FAIL pre_reset got rd=%06h busy=%b want FF00FF 1", r_data1, fill_busy1);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (fill_busy1 !== 1'b0 || disp_bank1 !== 1'b0 || r_data1 !== 24'h0 ||
        r_data2 !== 24'h0 || w_ready1 !== 1'b1 || fill_busy2 !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_fill got busy=%b disp=%b rd1=%h rd2=%h rdy=%b busy2=%b want 0 0 0 0 1 0",
               fill_busy1, disp_bank1, r_data1, r_data2, w_ready1, fill_busy2);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_disp = 0;
    vsync = 1'b1;
    tick();
    vsync = 1'b0;
    total++;
    if (swap_ack1 !== 1'b0) begin
      bad++;
      $display("FAIL reset_pend_clear got ack=%b want=0", swap_ack1);
    end
    fill_start = 1'b1; fill_bank = 1'b1; fill_data = 24'h445566;
    tick();
    fill_start = 1'b0;
    busy_cnt = 0;
    while (fill_busy1 === 1'b1 && busy_cnt < 1000) begin
      busy_cnt++;
      tick();
    end
    total++;
    if (busy_cnt !== 256 || fill_done1 !== 1'b1) begin
      bad++;
      $display("FAIL refill_len got=%0d done=%b want 256 1", busy_cnt, fill_done1);
    end
  endtask

  initial begin
    test_reset();
    test_read_latency();
    test_fill();
    test_swap();
    test_swap_blocked();
    test_sel_vsync_same();
    test_reset_mid_fill();
    repeat (2) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vid_palette_banked.md
Name: vid_palette_banked

Overview:
- Parametrised multi-bank palette memory for the video pipeline. It generalises the fixed 256x24 single-bank palette in depth, width and bank count.
- The CPU or bus side writes through a valid/ready port into any bank. A hardware fill engine clears or fills a whole bank at one entry per cycle.
- The displayed bank changes only on a vsync pulse, which gives tear-free palette swaps.
- The video scanout side reads the displayed bank with a fixed 1- or 2-cycle latency.

Parameters:
- ADDR_W, 8: palette index width; depth is 2^ADDR_W.
- DATA_W, 24: colour entry width.
- N_BANKS, 2: number of banks; power of 2, 1..8. BANK_W = max(1, clog2(N_BANKS)).
- RD_LAT, 1: read latency, 1 or 2. A value of 2 adds an output register.

Ports:
- clk  in  1  single clock for all logic
- rst_n  in  1  asynchronous active-low reset
- w_bank  in  BANK_W  write bank
- w_addr  in  ADDR_W  write index
- w_data  in  DATA_W  write colour
- w_valid  in  1  write request
- w_ready  out  1  write accepted when w_valid & w_ready
- fill_start  in  1  start bank fill, 1-cycle pulse
- fill_bank  in  BANK_W  bank to fill
- fill_data  in  DATA_W  fill colour, sampled at fill_start
- fill_busy  out  1  fill engine active
- fill_done  out  1  1-cycle pulse after the last fill write
- sel_valid  in  1  request a display-bank change
- sel_bank  in  BANK_W  requested display bank
- vsync  in  1  frame-boundary pulse, 1 cycle
- swap_ack  out  1  1-cycle pulse when the display bank changed
- disp_bank  out  BANK_W  currently displayed bank
- r_addr  in  ADDR_W  scanout read index
- r_data  out  DATA_W  colour for r_addr, RD_LAT cycles later

Behaviour:
- Storage: N_BANKS*2^ADDR_W x DATA_W synchronous RAM. One write port, one read port. Contents are not reset.
- Reset values: w_ready=1, fill_busy=0, fill_done=0, swap_ack=0, disp_bank=0, r_data=0, pending swap cleared, fill FSM=IDLE.
- Read address = {disp_bank, r_addr}.
  - r_data valid RD_LAT cycles after r_addr is presented.
  - The bank used is the disp_bank value in the cycle r_addr is sampled.
- Read/write collision (same bank and index, same cycle): read returns the old data.
- Write port:
  - w_ready = ~fill_busy.
  - An accepted write lands in the RAM at the end of that cycle.
  - Writes to the displayed bank are allowed and take effect immediately (tearing is the user's choice).
- Fill FSM, IDLE -> RUN -> IDLE:
  - In IDLE, fill_start latches fill_bank and fill_data, sets the counter to 0 and moves to RUN. fill_busy rises the next cycle.
  - In RUN, one write per cycle to {bank, cnt}, with cnt incrementing.
  - After the write at cnt = 2^ADDR_W-1 the FSM returns to IDLE. fill_busy drops and fill_done pulses in that same next cycle.
  - fill_busy is high for exactly 2^ADDR_W cycles.
  - fill_start while in RUN is ignored.
  - fill_start in the same cycle as an accepted w_valid: the write completes first, and the fill starts as normal.
- Swap logic:
  - sel_valid latches sel_bank into pend_bank and sets pend=1. A later sel_valid overwrites pend_bank.
  - On vsync with pend=1, the swap applies unless (fill_busy & pend_bank==fill bank). When it applies: disp_bank <= pend_bank, pend <= 0, and swap_ack pulses in the next cycle.
  - If blocked by a fill into the target bank, pend is kept and the swap is retried on the next vsync.
  - sel_valid and vsync in the same cycle: the swap uses the old pend state. The new request is latched and applied no earlier than the next vsync.
  - vsync with pend=0: no effect.
  - Selecting the bank already displayed still produces swap_ack.
- Reset mid-fill: the FSM returns to IDLE immediately. Partially filled RAM contents are left as-is.
- Bank index width: when N_BANKS=1, BANK_W=1, bank inputs are ignored and disp_bank stays 0.

Test Plan:
- Write bank0 idx 0x10 = 0x123456, idle 2 cycles, read idx 0x10 with RD_LAT=1 -> r_data=0x123456 exactly 1 cycle later; with RD_LAT=2 -> exactly 2 cycles later.
- fill_start bank1 data 0xFF00FF -> fill_busy high exactly 256 cycles, fill_done single pulse, w_ready low throughout. A w_valid held during the fill is accepted on the first cycle after busy drops.
- sel_valid bank1, then vsync 10 cycles later -> disp_bank=1 and swap_ack one cycle after vsync. Reads of idx 0 return 0xFF00FF from that cycle on; before it they return bank0 data.
- Start fill of bank0 while bank1 is displayed, sel_valid bank0, vsync during the fill -> no swap and no ack. The next vsync after fill_done swaps to 0 and pulses swap_ack.
- sel_valid bank1 and vsync in the same cycle with pend=0 -> no swap. The next vsync swaps to bank1.
- Assert rst_n low for 1 cycle at fill count 100 -> fill_busy=0, disp_bank=0, r_data=0, w_ready=1 immediately; a new fill_start afterwards runs the full 256 cycles.
